ddr_event_reader: RTL and testbench

- AXI4 read master that fetches one event buffer from DDR and streams it out as AXI4-Stream.
- Sits on the readout slave port of the DDR interconnect, opposite the header/TURFIO event writers.
- Takes a start address and beat count from the event controller.
- Splits the transfer into AXI INCR bursts without crossing 4 KB boundaries, tracks outstanding bursts, and marks the final beat with tlast.

---
 rtl/ddr_event_pkg.sv | 17 +
 rtl/ddr_burst_splitter.sv | 31 +++
 rtl/ddr_event_reader.sv | 178 +++++++++++++++++
 tb/tb_ddr_event_reader.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_event_pkg.sv
// Shared AXI constants and the reader FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ddr_event_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam int         BOUNDARY_4K = 4096;
  localparam int         ID_W        = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/ddr_burst_splitter.sv
// Burst sizer: blen = min(remain, MAX_BURST, beats left before the next 4 KB boundary).
// Latency: purely combinational.
// Backpressure: none; the caller holds addr/remain stable while the burst is pending.
// Ports: addr = low 12 bits of the beat-aligned byte address, remain = beats still
//        to request, blen = beats for the next INCR burst (never 0 when remain != 0).
module ddr_burst_splitter
  import ddr_event_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int MAX_BURST = 64
) (
  input  logic [11:0] addr,
  input  logic [15:0] remain,
  output logic [15:0] blen
);

  localparam int SIZE = $clog2(DATA_W / 8);

  logic [12:0] to_4k;
  logic [12:0] to_4k_beats;

  always_comb begin
    // 4096 - offset is in 1..4096, so 13 bits are enough.
    to_4k       = 13'(BOUNDARY_4K) - {1'b0, addr};
    to_4k_beats = to_4k >> SIZE;
    blen        = 16'(MAX_BURST);
    if (remain < blen) blen = remain;
    if ({3'b000, to_4k_beats} < blen) blen = {3'b000, to_4k_beats};
  end

endmodule

// File: rtl/ddr_event_reader.sv
// AXI4 read master: fetches one event buffer from DDR and streams it as AXI4-Stream.
// Latency: R -> AXIS is a zero-cycle pass-through; AR is registered (one burst in flight on AR).
// Backpressure: m_axis_tready drives m_axi_rready directly; AR stalls at MAX_OUTST bursts.
// Ports: cmd_* (start address / beat count, accepted only in IDLE), m_axi_ar* / m_axi_r*
//        (AXI4 read channels), m_axis_* (output stream, tlast on the final beat of the command),
//        done (pulse after the final beat), rd_err (sticky non-OKAY response flag).
// Optional: define DDR_EVENT_READER_STATS_EN to add stat_bursts / stat_stall counters.
module ddr_event_reader
  import ddr_event_pkg::*;
#(
  parameter int ADDR_W    = 34,
  parameter int DATA_W    = 64,
  parameter int MAX_BURST = 64,
  parameter int MAX_OUTST = 4,
  parameter int AXI_ID    = 0
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [15:0]       cmd_nbeats,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic [ID_W-1:0]   m_axi_arid,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic [ID_W-1:0]   m_axi_rid,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic              done,
  output logic              rd_err
`ifdef DDR_EVENT_READER_STATS_EN
  ,
  output logic [15:0]       stat_bursts,
  output logic [31:0]       stat_stall
`endif
);

  localparam int SIZE    = $clog2(DATA_W / 8);
  localparam int OUTST_W = $clog2(MAX_OUTST + 1);

  state_t             state, state_nxt;
  logic               ar_vld;
  logic [ADDR_W-1:0]  addr_q;
  logic [15:0]        ar_remain;
  logic [15:0]        r_remain;
  logic [15:0]        blen;
  logic [15:0]        blen_q;
  logic [7:0]         arlen_q;
  logic [OUTST_W-1:0] outst;

  logic cmd_acc, ar_hs, r_hs, last_hs;
  logic unused_rid;

  assign cmd_acc = cmd_valid & cmd_ready;
  assign ar_hs   = ar_vld & m_axi_arready;
  assign r_hs    = m_axi_rvalid & m_axis_tready;
  assign last_hs = r_hs & (r_remain == 16'd1);

  // Interleaving is never requested (single ID), so rid carries no information.
  assign unused_rid = ^m_axi_rid;

  ddr_burst_splitter #(
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
  ) u_split (
    .addr   (addr_q[11:0]),
    .remain (ar_remain),
    .blen   (blen)
  );

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (cmd_valid && cmd_nbeats != 16'd0) state_nxt = ST_ISSUE;
      ST_ISSUE: if (ar_hs && ar_remain == blen_q) state_nxt = ST_DRAIN;
      // r_remain==0 only guards against a stray extra beat having drained the count.
      ST_DRAIN: if (last_hs || r_remain == 16'd0) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    cmd_ready     = (state == ST_IDLE);
    m_axi_arvalid = ar_vld;
  end

  assign m_axi_araddr  = addr_q;   // addr_q only advances on the AR handshake
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = 3'(SIZE);
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arid    = ID_W'(AXI_ID);
  assign m_axi_rready  = m_axis_tready;
  assign m_axis_tdata  = m_axi_rdata;
  assign m_axis_tvalid = m_axi_rvalid;
  assign m_axis_tlast  = m_axi_rvalid & (r_remain == 16'd1);

  // Datapath: address/beat bookkeeping, AR register, status flags
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ar_vld    <= 1'b0;
      addr_q    <= '0;
      ar_remain <= '0;
      r_remain  <= '0;
      blen_q    <= '0;
      arlen_q   <= '0;
      outst     <= '0;
      done      <= 1'b0;
      rd_err    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cmd_acc) begin
        addr_q    <= cmd_addr;
        ar_remain <= cmd_nbeats;
        r_remain  <= cmd_nbeats;
        rd_err    <= 1'b0;
        done      <= (cmd_nbeats == 16'd0);
      end else begin
        if (ar_hs) begin
          ar_vld    <= 1'b0;
          addr_q    <= addr_q + (ADDR_W'(blen_q) << SIZE);
          ar_remain <= ar_remain - blen_q;
        end else if (state == ST_ISSUE && !ar_vld &&
                     outst < OUTST_W'(MAX_OUTST) && ar_remain != 16'd0) begin
          ar_vld  <= 1'b1;
          blen_q  <= blen;
          arlen_q <= 8'(blen - 16'd1);
        end
        if (r_hs) begin
          if (r_remain != 16'd0)       r_remain <= r_remain - 16'd1;
          if (m_axi_rresp != RESP_OKAY) rd_err   <= 1'b1;
          if (last_hs)                 done     <= 1'b1;
        end
      end
      // A burst issued and another retired in the same cycle cancel out.
      unique case ({ar_hs, r_hs & m_axi_rlast})
        2'b10:   outst <= outst + 1'b1;
        2'b01:   if (outst != '0) outst <= outst - 1'b1;
        default: outst <= outst;
      endcase
    end
  end

`ifdef DDR_EVENT_READER_STATS_EN
  // Per-command statistics, saturating.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stat_bursts <= '0;
      stat_stall  <= '0;
    end else if (cmd_acc) begin
      stat_bursts <= '0;
      stat_stall  <= '0;
    end else begin
      if (ar_hs && stat_bursts != '1) stat_bursts <= stat_bursts + 16'd1;
      if (m_axis_tvalid && !m_axis_tready && stat_stall != '1) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ddr_event_reader.sv
// Directed bench for ddr_event_reader with a behavioural AXI read slave and
// scoreboards for expected AR bursts and expected output beats.
module tb_ddr_event_reader;

  localparam int ADDR_W = 34;
  localparam int DATA_W = 64;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [ADDR_W-1:0] cmd_addr;
  logic [15:0]       cmd_nbeats;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] m_axi_araddr;
  logic [7:0]        m_axi_arlen;
  logic [2:0]        m_axi_arsize;
  logic [1:0]        m_axi_arburst;
  logic [2:0]        m_axi_arid;
  logic              m_axi_arvalid;
  logic              m_axi_arready;
  logic [DATA_W-1:0] m_axi_rdata;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rlast;
  logic [2:0]        m_axi_rid;
  logic              m_axi_rvalid;
  logic              m_axi_rready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready;
  logic              done;
  logic              rd_err;

  always #5 aclk = ~aclk;

  ddr_event_reader dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cmd_addr      (cmd_addr),
    .cmd_nbeats    (cmd_nbeats),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arsize  (m_axi_arsize),
    .m_axi_arburst (m_axi_arburst),
    .m_axi_arid    (m_axi_arid),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rlast   (m_axi_rlast),
    .m_axi_rid     (m_axi_rid),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .done          (done),
    .rd_err        (rd_err)
  );

  typedef struct { logic [63:0] d; logic last; } beat_t;
  typedef struct { logic [33:0] a; logic [7:0] len; } ar_t;
  typedef struct { logic [33:0] a; int len; int rdy; } burst_t;

  beat_t  exp_beats[$];
  ar_t    exp_ar[$];
  burst_t bq[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int bi = 0;
  int total_beats = 0;
  int ar_total = 0;
  int max_q = 0;
  int err_at = -1;
  int r_delay = 2;
  bit ar_rdy_en = 1'b1;
  bit tr_rand = 1'b0;
  bit exp_done = 1'b0;
  bit exp_err = 1'b0;

  function automatic logic [63:0] mem(input logic [33:0] a);
    return {~a[31:0], a[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_ar(input logic [33:0] a, input logic [7:0] l);
    ar_t e;
    e.a = a; e.len = l;
    exp_ar.push_back(e);
  endtask

  // AXI read slave plus output monitor. Samples at negedge (the values that
  // will handshake at the next posedge), updates and drives at posedge+1.
  task automatic slave_loop();
    bit ar_fire, r_fire, nd, ne;
    logic [33:0] ar_a;
    logic [7:0]  ar_l;
    beat_t b;
    ar_t e;
    burst_t nb;
    forever begin
      @(negedge aclk);
      ar_fire = 1'b0; r_fire = 1'b0; nd = 1'b0; ne = exp_err;
      ar_a = '0; ar_l = '0;
      if (aresetn !== 1'b1) begin
        ne = 1'b0;
      end else begin
        check("rready_mirror", m_axi_rready, m_axis_tready);
        check("done", done, exp_done);
        check("rd_err", rd_err, exp_err);
        if (cmd_valid && cmd_ready) begin
          ne = 1'b0;
          if (cmd_nbeats == 16'd0) nd = 1'b1;
        end
        ar_fire = m_axi_arvalid && m_axi_arready;
        if (ar_fire) begin
          ar_a = m_axi_araddr; ar_l = m_axi_arlen;
          if (exp_ar.size() == 0) check("ar_unexpected", 1, 0);
          else begin
            e = exp_ar.pop_front();
            check("araddr", ar_a, e.a);
            check("arlen", ar_l, e.len);
            check("ar_const", {m_axi_arsize, m_axi_arburst, m_axi_arid}, {3'd3, 2'b01, 3'd0});
          end
        end
        r_fire = m_axi_rvalid && m_axi_rready;
        if (r_fire) begin
          if (m_axi_rresp != 2'b00) ne = 1'b1;
          if (exp_beats.size() == 0) check("beat_unexpected", 1, 0);
          else begin
            b = exp_beats.pop_front();
            check("tdata", m_axis_tdata, b.d);
            check("tlast", m_axis_tlast, b.last);
            if (b.last) nd = 1'b1;
          end
        end
      end
      @(posedge aclk);
      #1;
      cyc++;
      if (aresetn !== 1'b1) begin
        bq.delete(); bi = 0; exp_done = 1'b0; exp_err = 1'b0;
      end else begin
        exp_done = nd; exp_err = ne;
        if (ar_fire) begin
          ar_total++;
          nb.a = ar_a; nb.len = int'(ar_l); nb.rdy = cyc + r_delay;
          bq.push_back(nb);
          if (bq.size() > max_q) max_q = bq.size();
        end
        if (r_fire && bq.size() > 0) begin
          total_beats++;
          if (bi == bq[0].len) begin
            void'(bq.pop_front());
            bi = 0;
          end else bi++;
        end
      end
      m_axi_arready = ar_rdy_en;
      m_axis_tready = tr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (aresetn === 1'b1 && bq.size() > 0 && cyc >= bq[0].rdy) begin
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = mem(bq[0].a + 34'(8 * bi));
        m_axi_rlast  = (bi == bq[0].len);
        m_axi_rresp  = (total_beats == err_at) ? 2'b10 : 2'b00;
      end else begin
        m_axi_rvalid = 1'b0;
        m_axi_rdata  = '0;
        m_axi_rlast  = 1'b0;
        m_axi_rresp  = 2'b00;
      end
    end
  endtask

  task automatic send_cmd(input logic [33:0] a, input logic [15:0] n);
    bit acc;
    beat_t b;
    @(posedge aclk);
    #1;
    cmd_addr = a; cmd_nbeats = n; cmd_valid = 1'b1;
    for (int i = 0; i < int'(n); i++) begin
      b.d = mem(a + 34'(8 * i));
      b.last = (i == int'(n) - 1);
      exp_beats.push_back(b);
    end
    acc = 1'b0;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge aclk);
      if (cmd_ready === 1'b1) acc = 1'b1;
    end
    @(posedge aclk);
    #1 cmd_valid = 1'b0;
    check("cmd_accept", acc, 1);
  endtask

  task automatic wait_done(input int budget, input string tag);
    bit seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge aclk);
      if (done === 1'b1) seen = 1'b1;
    end
    check(tag, seen, 1);
  endtask

  initial begin
    int base;
    aresetn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_nbeats = '0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0;
    m_axi_rlast = 1'b0; m_axi_rid = '0; m_axis_tready = 1'b1;
    fork
      slave_loop();
      begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
      end
    join_none

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    check("rst_arvalid", m_axi_arvalid, 0);
    check("rst_done", done, 0);
    check("rst_rd_err", rd_err, 0);
    @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    check("rst_cmd_ready", cmd_ready, 1);

    // 1: single 16-beat burst from 0
    push_ar(34'h0, 8'd15);
    send_cmd(34'h0, 16'd16);
    wait_done(200, "t1_done");
    check("t1_sb_empty", exp_beats.size() + exp_ar.size(), 0);

    // 2: 4 KB boundary split
    push_ar(34'h0FC0, 8'd7);
    push_ar(34'h1000, 8'd7);
    send_cmd(34'h0FC0, 16'd16);
    wait_done(200, "t2_done");
    check("t2_sb_empty", exp_beats.size() + exp_ar.size(), 0);

    // 3: 300 beats with slow R, outstanding limit
    r_delay = 50;
    push_ar(34'h2000, 8'd63);
    push_ar(34'h2200, 8'd63);
    push_ar(34'h2400, 8'd63);
    push_ar(34'h2600, 8'd63);
    push_ar(34'h2800, 8'd43);
    send_cmd(34'h2000, 16'd300);
    wait_done(2000, "t3_done");
    check("t3_sb_empty", exp_beats.size() + exp_ar.size(), 0);
    check("t3_max_outstanding", max_q, 4);
    r_delay = 2;

    // 4: random downstream backpressure
    tr_rand = 1'b1;
    push_ar(34'h3000, 8'd39);
    send_cmd(34'h3000, 16'd40);
    wait_done(1000, "t4_done");
    check("t4_sb_empty", exp_beats.size() + exp_ar.size(), 0);
    tr_rand = 1'b0;

    // 5: SLVERR on beat 5 of 8, then a zero-length command clears it
    err_at = total_beats + 4;
    push_ar(34'h4000, 8'd7);
    send_cmd(34'h4000, 16'd8);
    wait_done(200, "t5_done");
    check("t5_rd_err_set", rd_err, 1);
    check("t5_sb_empty", exp_beats.size() + exp_ar.size(), 0);
    err_at = -1;
    send_cmd(34'h4100, 16'd0);
    wait_done(10, "t5_zero_done");
    check("t5_rd_err_clear", rd_err, 0);
    check("t5_zero_no_ar", exp_ar.size(), 0);

    // 6: reset mid-transfer with an AR pending, then a clean command
    r_delay = 3;
    push_ar(34'h6000, 8'd63);
    push_ar(34'h6200, 8'd63);
    base = ar_total;
    send_cmd(34'h6000, 16'd128);
    for (int k = 0; k < 100 && ar_total < base + 1; k++) begin
      @(posedge aclk);
      #2;
    end
    ar_rdy_en = 1'b0;
    check("t6_first_ar", ar_total, base + 1);
    base = total_beats;
    for (int k = 0; k < 200 && total_beats < base + 5; k++) begin
      @(posedge aclk);
      #2;
    end
    check("t6_beats_flowing", total_beats >= base + 5, 1);
    check("t6_arvalid_pending", m_axi_arvalid, 1);
    @(posedge aclk);
    #3 aresetn = 1'b0;
    #1;
    check("t6_rst_arvalid", m_axi_arvalid, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_cmd_ready", cmd_ready, 1);
    exp_beats.delete();
    exp_ar.delete();
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    ar_rdy_en = 1'b1;
    r_delay = 2;
    push_ar(34'h7000, 8'd15);
    send_cmd(34'h7000, 16'd16);
    wait_done(200, "t6_done");
    check("t6_sb_empty", exp_beats.size() + exp_ar.size(), 0);
    check("t6_rd_err", rd_err, 0);

    repeat (2) @(posedge aclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
